// File: rtl/pir_scan_ctrl.sv
// Purpose : scans NUM_SENSORS PIR channels through one shared sampler, averages a 2^WIN_LOG2 window, raises alarm.
// Latency : avg_bus/avg_valid/alarm update one cycle after the final sample of a window is acked.
// Backpr. : req/ack handshake; smp_req and smp_sel stay stable until smp_ack (or the optional ack timeout).
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   enable, stop_alarm    system on/off switch; user alarm silence (level)
//   smp_req/smp_sel       registered sample request and channel index to the sampler
//   smp_ack/smp_data      sampler response; smp_data valid while smp_ack=1
//   avg_bus/avg_valid     last window averages (channel i at [i*DATA_W +: DATA_W]) and update pulse
//   alarm/alarm_mask      buzzer drive and LED mask of channels tripped in the current alarm
//   evt_count/peak_value  saturating count of tripped channels; highest tripping average
//   err_timeout           sticky sampler-timeout flag
//
// Optional feature macro: PIR_SCAN_TIMEOUT_EN (ack timeout; when undefined REQ waits forever and
// err_timeout is tied to 0).

module pir_scan_ctrl #(
  parameter int NUM_SENSORS = 3,
  parameter int DATA_W      = 7,
  parameter int WIN_LOG2    = 2,
  parameter int SAMPLE_DIV  = 4,
  parameter int THRESHOLD   = 50,
  parameter int ALARM_HOLD  = 100,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          stop_alarm,
  output logic                          smp_req,
  output logic [1:0]                    smp_sel,
  input  logic                          smp_ack,
  input  logic [DATA_W-1:0]             smp_data,
  output logic [NUM_SENSORS*DATA_W-1:0] avg_bus,
  output logic                          avg_valid,
  output logic                          alarm,
  output logic [NUM_SENSORS-1:0]        alarm_mask,
  output logic [7:0]                    evt_count,
  output logic [DATA_W-1:0]             peak_value,
  output logic                          err_timeout
);

  localparam int ACC_W  = DATA_W + WIN_LOG2;
  localparam int RND_W  = WIN_LOG2 + 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;

  localparam logic [DIV_W-1:0]  DIV_LOAD   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ALARM_HOLD - 1);
  localparam logic [RND_W-1:0]  WIN_ROUNDS = RND_W'(1 << WIN_LOG2);
  localparam logic [1:0]        LAST_SEL   = 2'(NUM_SENSORS - 1);
  localparam logic [DATA_W-1:0] THR        = DATA_W'(THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_REQ, S_EVAL, S_ALARM, S_CLEAR
  } state_t;

  state_t                        state_q, state_d;
  logic [DIV_W-1:0]              div_q, div_d;
  logic [1:0]                    sel_q, sel_d;
  logic [RND_W-1:0]              round_q, round_d;
  logic [ACC_W-1:0]              acc_q [NUM_SENSORS];
  logic [ACC_W-1:0]              acc_d [NUM_SENSORS];
  logic                          req_q, req_d;
  logic                          abort_q, abort_d;
  logic [HOLD_W-1:0]             hold_q, hold_d;
  logic [NUM_SENSORS*DATA_W-1:0] avg_q, avg_d;
  logic                          avg_valid_q, avg_valid_d;
  logic                          alarm_q, alarm_d;
  logic [NUM_SENSORS-1:0]        mask_q, mask_d;
  logic [7:0]                    evt_q, evt_d;
  logic [DATA_W-1:0]             peak_q, peak_d;

  // Window evaluation helpers, all derived from the current accumulators.
  logic [DATA_W-1:0]      avg_w [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] trip_w;
  logic [3:0]             trip_cnt;
  logic [8:0]             evt_sum;
  logic [7:0]             evt_sat;
  logic [DATA_W-1:0]      peak_cand;
  logic [RND_W-1:0]       round_inc;

  // Handshake completion: a real ack, or a timeout treated as an ack of value 0.
  logic              timeout_hit;
  logic              take;
  logic [DATA_W-1:0] sample;

  assign take      = (state_q == S_REQ) && (smp_ack || timeout_hit);
  assign sample    = smp_ack ? smp_data : '0;
  assign round_inc = round_q + RND_W'(1);

  always_comb begin
    trip_cnt  = '0;
    peak_cand = peak_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      avg_w[i]  = acc_q[i][ACC_W-1:WIN_LOG2];
      trip_w[i] = (avg_w[i] >= THR);
      trip_cnt  = trip_cnt + {3'd0, trip_w[i]};
      if (trip_w[i] && (avg_w[i] > peak_cand)) peak_cand = avg_w[i];
    end
  end

  assign evt_sum = {1'b0, evt_q} + {5'd0, trip_cnt};
  assign evt_sat = evt_sum[8] ? 8'hFF : evt_sum[7:0];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sel_d       = sel_q;
    round_d     = round_q;
    req_d       = req_q;
    abort_d     = abort_q;
    hold_d      = hold_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    alarm_d     = alarm_q;
    mask_d      = mask_q;
    evt_d       = evt_q;
    peak_d      = peak_q;
    for (int i = 0; i < NUM_SENSORS; i++) acc_d[i] = acc_q[i];

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          for (int i = 0; i < NUM_SENSORS; i++) acc_d[i] = '0;
          round_d = '0;
          div_d   = DIV_LOAD;
          state_d = S_WAIT_TICK;
        end
      end

      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (div_q == '0) begin
          sel_d   = '0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end

      S_REQ: begin
        // Enable may fall and rise again while we wait; remember the abort.
        if (!enable) abort_d = 1'b1;
        if (take) begin
          if (abort_q || !enable) begin
            req_d   = 1'b0;
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
              if (sel_q == 2'(i)) acc_d[i] = acc_q[i] + ACC_W'(sample);
            end
            if (sel_q < LAST_SEL) begin
              sel_d = sel_q + 2'd1;
            end else begin
              req_d   = 1'b0;
              round_d = round_inc;
              if (round_inc == WIN_ROUNDS) begin
                state_d = S_EVAL;
              end else begin
                div_d   = DIV_LOAD;
                state_d = S_WAIT_TICK;
              end
            end
          end
        end
      end

      S_EVAL: begin
        for (int i = 0; i < NUM_SENSORS; i++) acc_d[i] = '0;
        round_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < NUM_SENSORS; i++) avg_d[i*DATA_W +: DATA_W] = avg_w[i];
          avg_valid_d = 1'b1;
          if (trip_w != '0) begin
            mask_d  = trip_w;
            evt_d   = evt_sat;
            peak_d  = peak_cand;
            alarm_d = 1'b1;
            hold_d  = '0;
            state_d = S_ALARM;
          end else begin
            div_d   = DIV_LOAD;
            state_d = S_WAIT_TICK;
          end
        end
      end

      S_ALARM: begin
        if ((hold_q == HOLD_LAST) || stop_alarm || !enable) begin
          alarm_d = 1'b0;
          mask_d  = '0;
          hold_d  = '0;
          state_d = S_CLEAR;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      S_CLEAR: begin
        hold_d = '0;
        if (enable) begin
          div_d   = DIV_LOAD;
          state_d = S_WAIT_TICK;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      sel_q       <= '0;
      round_q     <= '0;
      req_q       <= 1'b0;
      abort_q     <= 1'b0;
      hold_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      mask_q      <= '0;
      evt_q       <= '0;
      peak_q      <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sel_q       <= sel_d;
      round_q     <= round_d;
      req_q       <= req_d;
      abort_q     <= abort_d;
      hold_q      <= hold_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
      mask_q      <= mask_d;
      evt_q       <= evt_d;
      peak_q      <= peak_d;
      for (int i = 0; i < NUM_SENSORS; i++) acc_q[i] <= acc_d[i];
    end
  end

`ifdef PIR_SCAN_TIMEOUT_EN
  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  // wait_q counts the cycles the current request has gone unanswered.
  assign timeout_hit = (state_q == S_REQ) && !smp_ack && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == S_REQ) && !take) wait_q <= wait_q + WAIT_W'(1);
      else                             wait_q <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  // ACK_TIMEOUT only matters with the timeout compiled in; keep it referenced.
  assign err_timeout = 1'b0 && (ACK_TIMEOUT > 0);
`endif

  assign smp_req    = req_q;
  assign smp_sel    = sel_q;
  assign avg_bus    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign alarm      = alarm_q;
  assign alarm_mask = mask_q;
  assign evt_count  = evt_q;
  assign peak_value = peak_q;

endmodule

// File: doc/pir_scan_ctrl.md
Name: pir_scan_ctrl

Overview:
Scan controller for the PIR motion datapath. It sequences one shared sensor sampler across NUM_SENSORS channels using a req/ack handshake. It accumulates a power-of-two window of samples per channel, computes per-channel averages and compares them against a threshold. It drives the alarm, LED mask, event counter and peak register that feed the display and buzzer logic.

Parameters:
NUM_SENSORS, 3, number of PIR channels scanned (2..4)
DATA_W, 7, sample and average width
WIN_LOG2, 2, log2 of samples per averaging window (window = 4 rounds)
SAMPLE_DIV, 4, clock cycles between the starts of scan rounds (minimum 1)
THRESHOLD, 50, motion threshold; channel trips when avg >= THRESHOLD
ALARM_HOLD, 100, maximum cycles spent in ALARM
ACK_TIMEOUT, 15, cycles to wait for smp_ack (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  system on/off (turn switch)
stop_alarm  in  1  user alarm silence, level
smp_req  out  1  sample request to the shared sampler
smp_sel  out  2  channel index for the current request
smp_ack  in  1  sampler has smp_data valid for smp_sel
smp_data  in  DATA_W  sample value, valid with smp_ack
avg_bus  out  NUM_SENSORS*DATA_W  last window averages; channel i at [i*DATA_W +: DATA_W]
avg_valid  out  1  one-cycle pulse when avg_bus updates
alarm  out  1  buzzer drive
alarm_mask  out  NUM_SENSORS  channels tripped in the current alarm (LEDs)
evt_count  out  8  running total of tripped channels, saturating
peak_value  out  DATA_W  highest average that has ever caused a trip
err_timeout  out  1  sticky flag: sampler failed to ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; accumulators, round counter, divider and hold counter cleared. smp_req drops immediately, with no handshake completion.
- States: IDLE, WAIT_TICK, REQ, EVAL, ALARM, CLEAR.
- IDLE: outputs held. When enable=1, clear the accumulators and go to WAIT_TICK.
- WAIT_TICK: divider counts SAMPLE_DIV-1..0. At 0, set smp_sel=0 and go to REQ.
- REQ: smp_req=1 with a stable smp_sel until a cycle where smp_ack=1. In that cycle:
  - acc[sel] += smp_data; acc width is DATA_W+WIN_LOG2, so no overflow is possible.
  - If sel < NUM_SENSORS-1: sel+1, and smp_req stays high.
  - Else: round+1. The next state is EVAL if round reached 2^WIN_LOG2, otherwise WAIT_TICK.
- smp_req is registered. The sampler may ack in the same cycle req rises. smp_ack with smp_req=0 is ignored.
- EVAL (1 cycle):
  - avg[i] = acc[i] >> WIN_LOG2, truncating; registered onto avg_bus; avg_valid=1.
  - mask[i] = avg[i] >= THRESHOLD.
  - Accumulators and round counter cleared.
  - If mask != 0: alarm_mask <= mask; evt_count <= min(255, evt_count + popcount(mask)); peak_value <= max(peak_value, max over tripped avg); go to ALARM. Otherwise go to WAIT_TICK.
- ALARM: alarm=1 and no sampling. The hold counter increments each cycle. Exit to CLEAR when any of these holds:
  - hold reaches ALARM_HOLD-1, or
  - stop_alarm=1, or
  - enable=0.
  If several exit conditions are true together, CLEAR is still the single result.
- CLEAR (1 cycle): alarm=0; alarm_mask=0; hold counter=0. Next state is WAIT_TICK if enable=1, otherwise IDLE. evt_count and peak_value persist until reset.
- enable falling:
  - In WAIT_TICK or EVAL: go to IDLE next cycle, discarding the partial window.
  - In REQ: keep smp_req high until the ack, discard the ack data, then go to IDLE.
- stop_alarm outside ALARM has no effect.

Optional Feature:
PIR_SCAN_TIMEOUT_EN
- Defined: a REQ wait counter runs while smp_req=1 without an ack. At ACK_TIMEOUT cycles, the sample is taken as 0, err_timeout is set, and sequencing proceeds as if acked. err_timeout clears only on reset.
- Undefined: REQ waits indefinitely and err_timeout is tied to 0.

Test Plan:
1. Defaults; sampler acks in the same cycle with all channels = 60; enable=1. Required response after 4 rounds: avg_valid pulse, each avg=60, alarm=1, alarm_mask=3'b111, evt_count=3, peak_value=60.
2. Channel 1 = 40,40,40,80 across the window, others 10. Required response: avg1=50 trips (boundary), mask=3'b010, evt_count+1. With channel 1 = 40,40,40,79: avg=49 and no alarm.
3. Alarm active with stop_alarm pulsed at hold=10. Required response: CLEAR the next cycle, then alarm=0 and alarm_mask=0, and scanning resumes; with no stop, alarm lasts exactly 100 cycles.
4. Sampler acks 3 cycles late. Required response: smp_req and smp_sel stay stable for the whole wait. Drop enable mid-REQ: smp_req holds until the ack, then the block enters IDLE with no avg_valid.
5. Force evt_count=254 with a 3-channel trip. Required response: evt_count saturates at 255. Assert rst_n=0 mid-REQ: smp_req=0 asynchronously and all outputs are 0.
6. With PIR_SCAN_TIMEOUT_EN defined, the sampler never acks. Required response: after 15 cycles err_timeout=1 and the channel takes a 0 sample. With the macro undefined, smp_req stays high indefinitely.
